// File: rtl/fir_tap_sequencer.sv
// FIR tap sequencer: accepts one sample per handshake, pulses the delay-line
// shift, walks the tap index across all coefficients with MAC enabled, then
// holds the result on a valid/ready output handshake.
module fir_tap_sequencer #(
  parameter int unsigned NUM_TAPS = 8,
  parameter int unsigned ADDR_W   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              shift_en,
  output logic [ADDR_W-1:0] tap_idx,
  output logic              acc_clr,
  output logic              mac_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        state_o,
  output logic [15:0]       done_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    MAC   = 2'd2,
    OUT   = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_TAP = ADDR_W'(NUM_TAPS - 1);

  state_t            state;
  logic [ADDR_W-1:0] tap_q;
  logic [15:0]       done_q;
  logic              run_ok;

  // Reset release passes through this flop ahead of the state register, so
  // the earliest acceptance is the second rising edge after rst rises.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_ok <= 1'b0;
    end else begin
      run_ok <= 1'b1;
    end
  end

  // Sequencer FSM with tap counter and completed-output counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      tap_q  <= '0;
      done_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && run_ok) begin
            state <= SHIFT;
          end
        end
        SHIFT: begin
          state <= MAC;
          tap_q <= '0;
        end
        MAC: begin
          if (tap_q == LAST_TAP) begin
            state <= OUT;
            tap_q <= '0;
          end else begin
            tap_q <= tap_q + ADDR_W'(1);
          end
        end
        OUT: begin
          if (out_ready) begin
            done_q <= done_q + 16'd1;
            state  <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          tap_q <= '0;
        end
      endcase
    end
  end

  // Outputs decode only registered state; no input-to-output paths.
  always_comb begin
    in_ready  = (state == IDLE);
    shift_en  = (state == SHIFT);
    mac_en    = (state == MAC);
    acc_clr   = (state == MAC) && (tap_q == '0);
    out_valid = (state == OUT);
    tap_idx   = (state == MAC) ? tap_q : '0;
    state_o   = state;
    done_cnt  = done_q;
  end

endmodule
